// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
//
// Purpose:
//   Bundles the control and status signals of the PLL lock supervisor.
//   Clock and reset are not part of the bundle. They stay as plain ports on
//   the supervisor.
//
// Signals:
//   en          run request (1 = sequence the PLL, 0 = go idle)
//   pll_locked  raw PLL LOCKED, asynchronous to the supervisor clock
//   pll_rst     PLL RESET, active high
//   sys_rst     downstream system reset, active high
//   clk_oe      forwarded-clock enable (ODDR2 CE)
//   fail        high while the supervisor has given up
//   state_o     current state encoding (debug)
//   retry_cnt   failed lock attempts since the last RUN
//   loss_cnt    lock losses seen while running, saturating at 255
//
// Modports:
//   master  drives en / pll_locked and observes the status (board / bench)
//   slave   the supervisor itself
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if;
  logic       en;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       clk_oe;
  logic       fail;
  logic [2:0] state_o;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    output en,
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  clk_oe,
    input  fail,
    input  state_o,
    input  retry_cnt,
    input  loss_cnt
  );

  modport slave (
    input  en,
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output clk_oe,
    output fail,
    output state_o,
    output retry_cnt,
    output loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   This block brings the clock-generation PLL up in a controlled order.
//   The sequence is:
//     1. pulse the PLL reset
//     2. wait for LOCKED
//     3. require LOCKED to stay stable for a qualification window
//     4. release the downstream reset and enable the forwarded clock
//   A lock timeout causes a retry. Losing lock while running starts the
//   sequence again. After too many failed attempts the block latches FAIL.
//   The block runs on the free-running board clock and never on a PLL output.
//   A PLL output stops while the PLL is in reset.
//
// Ports:
//   clk   free-running reference clock (50 MHz)
//   rst   synchronous active-high reset
//   bus   pll_lock_supervisor_if.slave. It carries:
//           inputs:  en, pll_locked (async)
//           outputs: pll_rst, sys_rst, clk_oe, fail, state_o,
//                    retry_cnt, loss_cnt
//
// Structure:
//   - pll_locked is synchronised by two flops before any use (lock_s_q).
//   - The next state, counters and outputs are computed in one always_comb.
//   - Every flop is updated in one always_ff.
//   - The outputs are decoded from the next state and registered.
//     Because of this they change on the same edge as the state register.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 7,
  parameter int CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_lock_supervisor_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  // Terminal counts. Each one is the cnt value seen on the last cycle of its
  // window.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

  // Synchroniser for the asynchronous LOCKED input.
  logic sync1_q;
  logic lock_s_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;

  logic pll_rst_q, pll_rst_d;
  logic sys_rst_q, sys_rst_d;
  logic clk_oe_q,  clk_oe_d;
  logic fail_q,    fail_d;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (!bus.en) begin
      // Dropping en overrides every other transition. The counters of
      // failed attempts and losses are kept for post-mortem inspection.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
        end

        S_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          // Lock is tested first. A lock that shows up on the timeout cycle
          // itself still wins.
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_PLL_RST;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_STABLE: begin
          // A glitch during qualification restarts the full lock wait.
          // The PLL reset is not pulsed again, and it does not count as a
          // failed attempt.
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            if (loss_q != 8'hFF) begin
              loss_d = loss_q + 1'b1;
            end
          end
        end

        S_FAIL: begin
          // FAIL is sticky. Only rst or dropping en (handled above) leave it.
          state_d = S_FAIL;
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // The outputs are a function of the state being entered. This lets the
    // output flops switch on the same edge as the state flop.
    pll_rst_d = (state_d == S_IDLE) || (state_d == S_PLL_RST) ||
                (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    clk_oe_d  = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      clk_oe_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync1_q   <= bus.pll_locked;
      lock_s_q  <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      clk_oe_q  <= clk_oe_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.clk_oe    = clk_oe_q;
  assign bus.fail      = fail_q;
  assign bus.state_o   = state_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Bench for pll_lock_supervisor, built around a scoreboard.
//   - The stimulus tasks drive the inputs on the falling edge of the clock.
//   - For each cycle, the stimulus asks the reference model what the
//     outputs must be after the next rising edge, and pushes that
//     expectation into a queue.
//   - A separate monitor pops one expectation 1 ns after every rising edge
//     and compares it with the DUT.
//   - A few spot checks against fixed constants pin down the directed
//     scenarios.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int RST_PULSE = 4;
  localparam int TIMEOUT   = 20;
  localparam int STABLE_N  = 8;
  localparam int MAXR      = 2;

  // State numbers as they appear on state_o.
  localparam int IDLE = 0, PLLRST = 1, WAITL = 2, STAB = 3, RUN = 4, FAILS = 5;

  logic clk;
  logic rst;

  pll_lock_supervisor_if ifc ();

  pll_lock_supervisor #(
    .RST_PULSE_CYC    (RST_PULSE),
    .LOCK_TIMEOUT_CYC (TIMEOUT),
    .LOCK_STABLE_CYC  (STABLE_N),
    .MAX_RETRY        (MAXR),
    .CNT_W            (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int pr;
    int sr;
    int oe;
    int fl;
    int rc;
    int lc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // -------------------------------------------------------------------------
  // Reference model.
  // It tracks the phase of the sequence, how long the phase has lasted, the
  // retry and loss tallies, and the two-cycle delay of LOCKED.
  // -------------------------------------------------------------------------
  int m_state = IDLE;
  int m_t     = 0;    // cycles already spent in the current phase
  int m_retry = 0;
  int m_loss  = 0;
  int m_d1    = 0;    // LOCKED as seen one edge ago
  int m_d2    = 0;    // LOCKED as seen two edges ago (what the FSM uses)

  task automatic model_step(input bit r, input bit e, input bit lk);
    int ns;
    int nt;
    if (r) begin
      m_state = IDLE; m_t = 0; m_retry = 0; m_loss = 0; m_d1 = 0; m_d2 = 0;
      return;
    end
    ns = m_state;
    nt = m_t + 1;
    if (!e) begin
      ns = IDLE;
      nt = 0;
    end else if (m_state == IDLE) begin
      ns = PLLRST; nt = 0; m_retry = 0;
    end else if (m_state == PLLRST) begin
      if (m_t + 1 == RST_PULSE) begin ns = WAITL; nt = 0; end
    end else if (m_state == WAITL) begin
      if (m_d2 == 1) begin
        ns = STAB; nt = 0;
      end else if (m_t + 1 == TIMEOUT) begin
        nt = 0;
        if (m_retry == MAXR) ns = FAILS;
        else begin ns = PLLRST; m_retry++; end
      end
    end else if (m_state == STAB) begin
      if (m_d2 == 0) begin
        ns = WAITL; nt = 0;
      end else if (m_t + 1 == STABLE_N) begin
        ns = RUN; nt = 0; m_retry = 0;
      end
    end else if (m_state == RUN) begin
      if (m_d2 == 0) begin
        ns = PLLRST; nt = 0;
        if (m_loss < 255) m_loss++;
      end
    end
    m_d2    = m_d1;
    m_d1    = int'(lk);
    m_state = ns;
    m_t     = nt;
  endtask

  function automatic exp_t model_outputs();
    exp_t x;
    x.st = m_state;
    x.pr = (m_state == IDLE || m_state == PLLRST || m_state == FAILS) ? 1 : 0;
    x.sr = (m_state == RUN) ? 0 : 1;
    x.oe = (m_state == RUN) ? 1 : 0;
    x.fl = (m_state == FAILS) ? 1 : 0;
    x.rc = m_retry;
    x.lc = m_loss;
    return x;
  endfunction

  // -------------------------------------------------------------------------
  // Comparison helper shared by the monitor and the spot checks.
  // -------------------------------------------------------------------------
  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("state_o",   int'(ifc.state_o),   e.st);
      cmp("pll_rst",   int'(ifc.pll_rst),   e.pr);
      cmp("sys_rst",   int'(ifc.sys_rst),   e.sr);
      cmp("clk_oe",    int'(ifc.clk_oe),    e.oe);
      cmp("fail",      int'(ifc.fail),      e.fl);
      cmp("retry_cnt", int'(ifc.retry_cnt), e.rc);
      cmp("loss_cnt",  int'(ifc.loss_cnt),  e.lc);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  // Drive one cycle, then push what the outputs must be after the next edge.
  task automatic step(input bit r, input bit e, input bit lk);
    @(negedge clk);
    rst            = r;
    ifc.en         = e;
    ifc.pll_locked = lk;
    model_step(r, e, lk);
    exp_q.push_back(model_outputs());
  endtask

  task automatic cycles(input int n, input bit r, input bit e, input bit lk);
    for (int i = 0; i < n; i++) step(r, e, lk);
  endtask

  // Drive constant inputs until the model enters the target state.
  // If the budget runs out first, that counts as a failure.
  task automatic run_until(input int st, input int budget, input bit e, input bit lk,
                           input string nm);
    int n;
    n = 0;
    while (m_state != st && n < budget) begin
      step(1'b0, e, lk);
      n++;
    end
    checks++;
    if (m_state != st) begin
      errors++;
      $display("FAIL %s timeout: model state %0d, wanted %0d", nm, m_state, st);
    end
  endtask

  // Let the last driven edge land, then sample the outputs.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  int hi_run;
  int lk_run;
  bit lk_r;
  bit en_r;

  initial begin
    rst            = 1'b1;
    ifc.en         = 1'b0;
    ifc.pll_locked = 1'b0;

    // 1: reset, then never lock. Three attempts are made, then FAIL.
    cycles(3, 1'b1, 1'b1, 1'b0);
    settle();
    cmp("reset pll_rst", int'(ifc.pll_rst), 1);
    cmp("reset sys_rst", int'(ifc.sys_rst), 1);
    cmp("reset clk_oe",  int'(ifc.clk_oe),  0);
    cmp("reset state",   int'(ifc.state_o), 0);
    run_until(PLLRST, 5, 1'b1, 1'b0, "first attempt");
    // Count the length of the first PLL reset pulse directly on the DUT.
    hi_run = 0;
    settle();
    while (ifc.pll_rst == 1'b1 && hi_run < 50) begin
      hi_run++;
      step(1'b0, 1'b1, 1'b0);
      settle();
    end
    cmp("pll_rst pulse length", hi_run, RST_PULSE);
    run_until(FAILS, 200, 1'b1, 1'b0, "reach FAIL");
    cycles(5, 1'b0, 1'b1, 1'b0);
    settle();
    cmp("fail latched", int'(ifc.fail),      1);
    cmp("fail state",   int'(ifc.state_o),   5);
    cmp("fail retries", int'(ifc.retry_cnt), 2);
    cmp("fail pll_rst", int'(ifc.pll_rst),   1);

    // 6a: en=0 leaves FAIL for IDLE, and the retry count is held.
    cycles(2, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("idle state", int'(ifc.state_o),   0);
    cmp("idle fail",  int'(ifc.fail),      0);
    cmp("idle retry", int'(ifc.retry_cnt), 2);

    // 2: lock appears 5 cycles after pll_rst falls, then the block reaches RUN.
    run_until(WAITL, 20, 1'b1, 1'b0, "to WAIT_LOCK");
    cycles(4, 1'b0, 1'b1, 1'b0);
    run_until(RUN, 40, 1'b1, 1'b1, "to RUN");
    settle();
    cmp("run sys_rst", int'(ifc.sys_rst),   0);
    cmp("run clk_oe",  int'(ifc.clk_oe),    1);
    cmp("run retry",   int'(ifc.retry_cnt), 0);

    // 3: a 1-cycle lock drop in RUN re-sequences. Relock restores RUN.
    step(1'b0, 1'b1, 1'b0);
    run_until(PLLRST, 5, 1'b1, 1'b1, "loss to PLL_RST");
    settle();
    cmp("loss sys_rst", int'(ifc.sys_rst),  1);
    cmp("loss clk_oe",  int'(ifc.clk_oe),   0);
    cmp("loss count",   int'(ifc.loss_cnt), 1);
    run_until(RUN, 40, 1'b1, 1'b1, "relock RUN");

    // 4: a 3-cycle glitch in the middle of STABLE sends the block back to
    //    WAIT_LOCK.
    step(1'b0, 1'b1, 1'b0);
    run_until(STAB, 40, 1'b1, 1'b1, "to STABLE");
    cycles(3, 1'b0, 1'b1, 1'b1);
    cycles(3, 1'b0, 1'b1, 1'b0);
    run_until(WAITL, 10, 1'b1, 1'b0, "glitch to WAIT_LOCK");
    settle();
    cmp("glitch no retry", int'(ifc.retry_cnt), 0);
    run_until(RUN, 60, 1'b1, 1'b1, "post-glitch RUN");

    // 5: lock is first seen on the last cycle of the timeout window.
    cycles(1, 1'b0, 1'b0, 1'b0);
    run_until(WAITL, 20, 1'b1, 1'b0, "late-lock WAIT_LOCK");
    while (m_state == WAITL && m_t < TIMEOUT - 3) step(1'b0, 1'b1, 1'b0);
    run_until(STAB, 5, 1'b1, 1'b1, "late lock wins");
    settle();
    cmp("late lock state", int'(ifc.state_o), 3);
    cmp("late lock retry", int'(ifc.retry_cnt), 0);

    // 6b: rst while in RUN returns every output to its reset value.
    run_until(RUN, 30, 1'b1, 1'b1, "to RUN for rst");
    step(1'b0, 1'b1, 1'b0);
    run_until(RUN, 40, 1'b1, 1'b1, "RUN with loss");
    step(1'b1, 1'b1, 1'b1);
    settle();
    cmp("rst state",   int'(ifc.state_o),  0);
    cmp("rst pll_rst", int'(ifc.pll_rst),  1);
    cmp("rst sys_rst", int'(ifc.sys_rst),  1);
    cmp("rst clk_oe",  int'(ifc.clk_oe),   0);
    cmp("rst loss",    int'(ifc.loss_cnt), 0);

    // Random phase: LOCKED comes in runs of random length, with occasional
    // en drops and resets.
    lk_r   = 1'b0;
    lk_run = 0;
    en_r   = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (lk_run == 0) begin
        lk_r   = ~lk_r;
        lk_run = lk_r ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 25));
      end
      lk_run--;
      if ($urandom_range(0, 299) == 0) en_r = ~en_r;
      if (!en_r && $urandom_range(0, 9) == 0) en_r = 1'b1;
      step(($urandom_range(0, 799) == 0), en_r, lk_r);
    end

    repeat (3) @(posedge clk);
    #3;
    cmp("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
